// File: rtl/wiredpanda_io_pkg.sv
// Shared constants and helpers for the wiRedPanda input conditioning blocks.
// Defaults match a 2-flop synchroniser and a 16-cycle debounce window.
package wiredpanda_io_pkg;

    localparam int WP_SYNC_STAGES     = 2;
    localparam int WP_DEBOUNCE_CYCLES = 16;

    // Wide enough to hold DEBOUNCE_CYCLES, although the counter itself stops at DEBOUNCE_CYCLES-1.
    function automatic int wp_cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/wiredpanda_debounce_channel.sv
// One debounced button: synchroniser chain, persistence counter, accepted level
// and registered rise/fall pulses that coincide with the level change.
module wiredpanda_debounce_channel
    import wiredpanda_io_pkg::*;
#(
    parameter int SYNC_STAGES     = WP_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = WP_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W   = wp_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   stable;
    logic [CNT_W-1:0]       cnt;

    assign s     = sync[SYNC_STAGES-1];
    assign level = stable;

    // Only sync[0] may go metastable; later stages give it time to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Any cycle where the synchronised value matches the accepted one restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s;
                cnt    <= '0;
                rise   <= s;
                fall   <= ~s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wiredpanda_input_debouncer.sv
// Debounces N_INPUTS raw push-buttons for a generated wiRedPanda logic module
// and flags any accepted edge on btn_changed.
module wiredpanda_input_debouncer
    import wiredpanda_io_pkg::*;
#(
    parameter int N_INPUTS        = 2,
    parameter int SYNC_STAGES     = WP_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = WP_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] btn_raw,
    output logic [N_INPUTS-1:0] btn_level,
    output logic [N_INPUTS-1:0] btn_rise,
    output logic [N_INPUTS-1:0] btn_fall,
    output logic                btn_changed
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "wiredpanda_input_debouncer: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $fatal(1, "wiredpanda_input_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_chan
        wiredpanda_debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i]),
            .fall (btn_fall[i])
        );
    end

    assign btn_changed = |(btn_rise | btn_fall);

endmodule

// File: tb/tb_wiredpanda_input_debouncer.sv
// Bench for wiredpanda_input_debouncer: per-edge vector tables with a scoreboard
// queue, plus hand-written reset and parameter-sweep sequences.
module tb_wiredpanda_input_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic       btn_changed;

    logic [0:0] sw_raw;
    logic [0:0] sw_level;
    logic [0:0] sw_rise;
    logic [0:0] sw_fall;
    logic       sw_changed;

    always #5 clk = ~clk;

    wiredpanda_input_debouncer #(
        .N_INPUTS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_rise(btn_rise), .btn_fall(btn_fall), .btn_changed(btn_changed)
    );

    wiredpanda_input_debouncer #(
        .N_INPUTS(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)
    ) u_sweep (
        .clk(clk), .rst_n(rst_n), .btn_raw(sw_raw), .btn_level(sw_level),
        .btn_rise(sw_rise), .btn_fall(sw_fall), .btn_changed(sw_changed)
    );

    typedef struct {
        logic [1:0] raw;
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       changed;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;

    task automatic push_vec(input logic [1:0] raw, input logic [1:0] level,
                            input logic [1:0] rise, input logic [1:0] fall);
        vec_t v;
        v.raw     = raw;
        v.level   = level;
        v.rise    = rise;
        v.fall    = fall;
        v.changed = |(rise | fall);
        vecs.push_back(v);
    endtask

    task automatic hold(input logic [1:0] raw, input logic [1:0] level, input int n);
        for (int i = 0; i < n; i++) push_vec(raw, level, 2'b00, 2'b00);
    endtask

    task automatic check_output(input string name);
        vec_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s: scoreboard empty, nothing expected", name);
            return;
        end
        e = exp_q.pop_front();
        if (btn_level !== e.level || btn_rise !== e.rise || btn_fall !== e.fall ||
            btn_changed !== e.changed) begin
            bad++;
            $display("[TB] FAIL %s: got level=%b rise=%b fall=%b changed=%b, want level=%b rise=%b fall=%b changed=%b",
                     name, btn_level, btn_rise, btn_fall, btn_changed,
                     e.level, e.rise, e.fall, e.changed);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string name);
        @(negedge clk);
        btn_raw = v.raw;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_output(name);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], $sformatf("%s_e%0d", tag, i));
        end
        vecs.delete();
    endtask

    task automatic expect_now(input string name, input logic [1:0] level,
                              input logic [1:0] rise, input logic [1:0] fall);
        vec_t v;
        v.raw     = btn_raw;
        v.level   = level;
        v.rise    = rise;
        v.fall    = fall;
        v.changed = |(rise | fall);
        exp_q.push_back(v);
        check_output(name);
    endtask

    task automatic check_sweep(input string name, input logic level, input logic rise,
                               input logic fall);
        total++;
        if (sw_level !== level || sw_rise !== rise || sw_fall !== fall ||
            sw_changed !== (rise | fall)) begin
            bad++;
            $display("[TB] FAIL %s: got level=%b rise=%b fall=%b changed=%b, want level=%b rise=%b fall=%b changed=%b",
                     name, sw_level, sw_rise, sw_fall, sw_changed, level, rise, fall, rise | fall);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic bounce [9];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n   = 1'b0;
        btn_raw = 2'b00;
        sw_raw  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset_state", 2'b00, 2'b00, 2'b00);
        check_sweep("sweep_reset_state", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press and release on channel 0: edges 5 and 13.
        hold(2'b01, 2'b00, 5);
        push_vec(2'b01, 2'b01, 2'b01, 2'b00);
        hold(2'b01, 2'b01, 2);
        hold(2'b00, 2'b01, 5);
        push_vec(2'b00, 2'b00, 2'b00, 2'b01);
        hold(2'b00, 2'b00, 1);
        run_table("press");

        // Bounce: last synchronised 0->1 at edge 6, accepted at edge 10.
        for (int i = 0; i < 9; i++) hold(bounce[i] ? 2'b01 : 2'b00, 2'b00, 1);
        hold(2'b01, 2'b00, 1);
        push_vec(2'b01, 2'b01, 2'b01, 2'b00);
        hold(2'b01, 2'b01, 1);
        hold(2'b00, 2'b01, 5);
        push_vec(2'b00, 2'b00, 2'b00, 2'b01);
        hold(2'b00, 2'b00, 1);
        run_table("bounce");

        // Three-cycle glitch is rejected; four-cycle pulse is accepted then released.
        hold(2'b01, 2'b00, 3);
        hold(2'b00, 2'b00, 7);
        hold(2'b01, 2'b00, 4);
        hold(2'b00, 2'b00, 1);
        push_vec(2'b00, 2'b01, 2'b01, 2'b00);
        hold(2'b00, 2'b01, 3);
        push_vec(2'b00, 2'b00, 2'b00, 2'b01);
        hold(2'b00, 2'b00, 2);
        run_table("glitch");

        // Both channels rise together, then channel 1 falls alone.
        hold(2'b11, 2'b00, 5);
        push_vec(2'b11, 2'b11, 2'b11, 2'b00);
        hold(2'b11, 2'b11, 1);
        hold(2'b01, 2'b11, 5);
        push_vec(2'b01, 2'b01, 2'b00, 2'b10);
        hold(2'b01, 2'b01, 1);
        hold(2'b00, 2'b01, 5);
        push_vec(2'b00, 2'b00, 2'b00, 2'b01);
        hold(2'b00, 2'b00, 1);
        run_table("indep");

        // Establish level 10 so the asynchronous clear is visible.
        hold(2'b10, 2'b00, 5);
        push_vec(2'b10, 2'b10, 2'b10, 2'b00);
        hold(2'b10, 2'b10, 2);
        run_table("presetup");

        @(negedge clk);
        btn_raw = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        expect_now("midcount_edge2", 2'b10, 2'b00, 2'b00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_now("reset_async_clear", 2'b00, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        expect_now("reset_held_edge3", 2'b00, 2'b00, 2'b00);
        #1;
        rst_n = 1'b1;

        // Raw held at 11 through reset: full latency from first post-reset edge.
        hold(2'b11, 2'b00, 5);
        push_vec(2'b11, 2'b11, 2'b11, 2'b00);
        hold(2'b11, 2'b11, 1);
        hold(2'b00, 2'b11, 5);
        push_vec(2'b00, 2'b00, 2'b00, 2'b11);
        hold(2'b00, 2'b00, 1);
        run_table("postreset");

        // SYNC_STAGES=3, DEBOUNCE_CYCLES=1: level follows at edge 3.
        @(negedge clk);
        sw_raw = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            check_sweep($sformatf("sweep_rise_e%0d", e), e >= 3, e == 3, 1'b0);
        end
        @(negedge clk);
        sw_raw = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            check_sweep($sformatf("sweep_fall_e%0d", e), e < 3, 1'b0, e == 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
